jtag_dv: RTL and testbench

- JTAG test access port (TAP) plus RISC-V debug transport module (DTM) that bridges a 5-bit-IR JTAG port to a debug module interface (DMI) request/response port.
- Sits between the chip JTAG pins and the debug module.
- Serves IDCODE reads and DMI reads/writes issued by the JTAG debug driver, including system-bus accesses and abstract commands.

---
 rtl/jtag_dv.sv | 222 ++++++++++++++++++++++
 tb/tb_jtag_dv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dv.sv
// jtag_dv: IEEE 1149.1 TAP with a RISC-V debug transport module bridging
// the JTAG data registers to a DMI request/response port. Rev 1.0
`default_nettype none

module jtag_dv #(
  parameter logic [31:0] IdCode   = 32'h1000_0001,
  parameter int unsigned DmiAbits = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  output logic [DmiAbits-1:0] dmi_req_addr_o,
  output logic [1:0]          dmi_req_op_o,
  output logic [31:0]         dmi_req_data_o,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o,
  input  logic [31:0]         dmi_resp_data_i,
  input  logic [1:0]          dmi_resp_resp_i,
  output logic                dmi_rst_no
);

  localparam int unsigned DrW = DmiAbits + 34;

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle,
    SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
    SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  typedef enum logic [1:0] {SelBypass, SelIdcode, SelDtmcs, SelDmi} dr_sel_e;

  tap_state_e state_q, state_d;
  dr_sel_e    dr_sel;

  logic [4:0]          ir_q, ir_d;
  logic [4:0]          ir_shift_q, ir_shift_d;
  logic [DrW-1:0]      dr_q, dr_d;
  logic [1:0]          sticky_q, sticky_d;
  logic                req_valid_q, req_valid_d;
  logic                resp_pending_q, resp_pending_d;
  logic [DmiAbits-1:0] req_addr_q, req_addr_d;
  logic [31:0]         req_data_q, req_data_d;
  logic [1:0]          req_op_q, req_op_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                dmi_rst_n_q, dmi_rst_n_d;

  logic                resp_fire;
  logic [1:0]          sticky_now;
  logic                busy_now;
  logic [1:0]          dmi_status;
  logic [31:0]         resp_data_now;
  logic [31:0]         dtmcs_val;
  logic [1:0]          upd_op;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_comb begin
    dr_sel = SelBypass;
    case (ir_q)
      IrIdcode: dr_sel = SelIdcode;
      IrDtmcs:  dr_sel = SelDtmcs;
      IrDmi:    dr_sel = SelDmi;
      default:  dr_sel = SelBypass;
    endcase
  end

  // Status/data as they will stand after this edge, so a response landing
  // in the same cycle as Capture-DR is already reflected in the capture.
  assign resp_fire     = dmi_resp_valid_i && resp_pending_q;
  assign sticky_now    = (resp_fire && (dmi_resp_resp_i != 2'd0) && (sticky_q == 2'd0))
                         ? 2'd2 : sticky_q;
  assign busy_now      = req_valid_q || (resp_pending_q && !resp_fire);
  assign dmi_status    = (sticky_now != 2'd0) ? sticky_now : (busy_now ? 2'd3 : 2'd0);
  assign resp_data_now = resp_fire ? dmi_resp_data_i : resp_data_q;
  assign dtmcs_val     = {17'd0, 3'd1, sticky_now, 6'(DmiAbits), 4'd1};
  assign upd_op        = dr_q[1:0];

  always_comb begin
    ir_d           = ir_q;
    ir_shift_d     = ir_shift_q;
    dr_d           = dr_q;
    sticky_d       = sticky_now;
    req_valid_d    = req_valid_q;
    resp_pending_d = resp_pending_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    req_op_d       = req_op_q;
    resp_data_d    = resp_data_now;
    dmi_rst_n_d    = 1'b1;

    if (req_valid_q && dmi_req_ready_i) begin
      req_valid_d    = 1'b0;
      resp_pending_d = 1'b1;
    end
    if (resp_fire) begin
      resp_pending_d = 1'b0;
    end

    case (state_q)
      CaptureIr: ir_shift_d = 5'b00001;
      ShiftIr:   ir_shift_d = {tdi_i, ir_shift_q[4:1]};
      UpdateIr:  ir_d       = ir_shift_q;
      CaptureDr: begin
        case (dr_sel)
          SelIdcode: dr_d = {{(DrW-32){1'b0}}, IdCode};
          SelDtmcs:  dr_d = {{(DrW-32){1'b0}}, dtmcs_val};
          SelDmi:    dr_d = {req_addr_q, resp_data_now, dmi_status};
          default:   dr_d = '0;
        endcase
      end
      ShiftDr: begin
        case (dr_sel)
          SelIdcode, SelDtmcs: dr_d = {{(DrW-32){1'b0}}, tdi_i, dr_q[31:1]};
          SelDmi:              dr_d = {tdi_i, dr_q[DrW-1:1]};
          default:             dr_d = {{(DrW-1){1'b0}}, tdi_i};
        endcase
      end
      UpdateDr: begin
        if (dr_sel == SelDtmcs) begin
          if (dr_q[16]) sticky_d = 2'd0;
          if (dr_q[17]) begin
            sticky_d       = 2'd0;
            req_valid_d    = 1'b0;
            resp_pending_d = 1'b0;
            dmi_rst_n_d    = 1'b0;
          end
        end else if (dr_sel == SelDmi && (upd_op == 2'd1 || upd_op == 2'd2)) begin
          if (sticky_q != 2'd0) begin
            sticky_d = sticky_now;
          end else if (req_valid_q || resp_pending_q) begin
            sticky_d = 2'd3;
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = dr_q[DrW-1:34];
            req_data_d  = dr_q[33:2];
            req_op_d    = upd_op;
          end
        end
      end
      default: ;
    endcase

    if (state_d == TestLogicReset) begin
      ir_d     = IrIdcode;
      sticky_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= TestLogicReset;
      ir_q           <= IrIdcode;
      ir_shift_q     <= '0;
      dr_q           <= '0;
      sticky_q       <= 2'd0;
      req_valid_q    <= 1'b0;
      resp_pending_q <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      req_op_q       <= 2'd0;
      resp_data_q    <= '0;
      dmi_rst_n_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      dr_q           <= dr_d;
      sticky_q       <= sticky_d;
      req_valid_q    <= req_valid_d;
      resp_pending_q <= resp_pending_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      req_op_q       <= req_op_d;
      resp_data_q    <= resp_data_d;
      dmi_rst_n_q    <= dmi_rst_n_d;
    end
  end

  assign tdo_oe_o = (state_q == ShiftIr) || (state_q == ShiftDr);
  assign tdo_o    = (state_q == ShiftIr) ? ir_shift_q[0] :
                    (state_q == ShiftDr) ? dr_q[0] : 1'b0;

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_op_o     = req_op_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_resp_ready_o = 1'b1;
  assign dmi_rst_no       = dmi_rst_n_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_dv.sv
// tb_jtag_dv: directed JTAG/DMI vectors against jtag_dv with hand-computed expectations.
`default_nettype none

module tb_jtag_dv;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tms_i;
  logic        tdi_i;
  logic        tdo_o;
  logic        tdo_oe_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_resp_i;
  logic        dmi_rst_no;

  int total = 0;
  int bad   = 0;

  jtag_dv #(.IdCode(32'h1000_0001), .DmiAbits(7)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .tms_i            (tms_i),
    .tdi_i            (tdi_i),
    .tdo_o            (tdo_o),
    .tdo_oe_o         (tdo_oe_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_resp_i  (dmi_resp_resp_i),
    .dmi_rst_no       (dmi_rst_no)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; samples tdo, drives pins, advances one TCK.
  task automatic step(input logic tms, input logic tdi, output logic tdo);
    tdo   = tdo_o;
    tms_i = tms;
    tdi_i = tdi;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, d);
  endtask

  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic d;
    step(1'b1, 1'b0, d); step(1'b1, 1'b0, d); step(1'b0, 1'b0, d); step(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) step(i == 4, din[i], dout[i]);
    step(1'b1, 1'b0, d); step(1'b0, 1'b0, d);
  endtask

  task automatic shift_dr(input logic [40:0] din, input int len, output logic [40:0] dout);
    logic d;
    dout = '0;
    step(1'b1, 1'b0, d); step(1'b0, 1'b0, d); step(1'b0, 1'b0, d);
    for (int i = 0; i < len; i++) step(i == len - 1, din[i], dout[i]);
    step(1'b1, 1'b0, d); step(1'b0, 1'b0, d);
  endtask

  task automatic accept_and_respond(input logic [31:0] data, input logic [1:0] resp);
    logic d;
    dmi_req_ready_i = 1'b1;
    step(1'b0, 1'b0, d);
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = data;
    dmi_resp_resp_i  = resp;
    step(1'b0, 1'b0, d);
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_resp_i  = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  ir_out;
    logic [40:0] dr_out;
    logic        d;

    rst_ni = 1'b0; tms_i = 1'b1; tdi_i = 1'b0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i = '0; dmi_resp_resp_i = 2'd0;
    @(negedge clk_i);
    step(1'b1, 1'b0, d); step(1'b1, 1'b0, d);

    check("rst_tdo", tdo_o, 1'b0);
    check("rst_tdo_oe", tdo_oe_o, 1'b0);
    check("rst_req_valid", dmi_req_valid_o, 1'b0);
    check("rst_req_fields", {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, '0);
    check("rst_resp_ready", dmi_resp_ready_o, 1'b1);
    check("rst_dmi_rst_n", dmi_rst_no, 1'b1);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, d);

    shift_dr('0, 32, dr_out);
    check("idcode", dr_out, 41'h1000_0001);

    shift_ir(5'h1F, ir_out);
    check("ir_capture_1f", ir_out, 5'b00001);
    shift_dr(41'b1101, 4, dr_out);
    check("bypass_1f", dr_out, 41'b1010);

    shift_ir(5'h05, ir_out);
    check("ir_capture_05", ir_out, 5'b00001);
    shift_dr(41'b1101, 4, dr_out);
    check("bypass_05", dr_out, 41'b1010);

    shift_ir(5'h10, ir_out);
    shift_dr('0, 32, dr_out);
    check("dtmcs_default", dr_out, 41'h0000_1071);

    // Write request with ready held low, then accepted.
    shift_ir(5'h11, ir_out);
    shift_dr({7'h38, 32'h0002_0804, 2'd2}, 41, dr_out);
    check("dmi_cap_initial", dr_out, '0);
    check("wr_valid", dmi_req_valid_o, 1'b1);
    check("wr_fields", {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, {7'h38, 32'h0002_0804, 2'd2});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, d);
      check("wr_hold", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o},
            {1'b1, 7'h38, 32'h0002_0804, 2'd2});
    end
    dmi_req_ready_i = 1'b1;
    step(1'b0, 1'b0, d);
    dmi_req_ready_i = 1'b0;
    check("wr_valid_drop", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1;
    step(1'b0, 1'b0, d);
    dmi_resp_valid_i = 1'b0;

    // Read request and response capture.
    shift_dr({7'h3C, 32'h0, 2'd1}, 41, dr_out);
    check("rd_cap_prev", dr_out, {7'h38, 32'h0, 2'd0});
    check("rd_fields", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o}, {1'b1, 7'h3C, 2'd1});
    accept_and_respond(32'hCAFE_0001, 2'd0);
    shift_dr('0, 41, dr_out);
    check("rd_result", dr_out, {7'h3C, 32'hCAFE_0001, 2'd0});

    // Second op while a response is outstanding.
    shift_dr({7'h10, 32'h0, 2'd1}, 41, dr_out);
    dmi_req_ready_i = 1'b1;
    step(1'b0, 1'b0, d);
    dmi_req_ready_i = 1'b0;
    shift_dr({7'h11, 32'h0, 2'd1}, 41, dr_out);
    check("busy_status", dr_out, {7'h10, 32'hCAFE_0001, 2'd3});
    check("busy_dropped", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h1234_5678;
    step(1'b0, 1'b0, d);
    dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0;
    shift_dr({7'h22, 32'h0, 2'd1}, 41, dr_out);
    check("sticky_status", dr_out, {7'h10, 32'h1234_5678, 2'd3});
    check("sticky_dropped", dmi_req_valid_o, 1'b0);

    shift_ir(5'h10, ir_out);
    shift_dr(41'h0001_0000, 32, dr_out);
    check("dtmcs_sticky3", dr_out, 41'h0000_1C71);
    shift_dr('0, 32, dr_out);
    check("dtmcs_cleared", dr_out, 41'h0000_1071);

    shift_ir(5'h11, ir_out);
    shift_dr({7'h22, 32'h0, 2'd1}, 41, dr_out);
    check("post_clear_status", dr_out, {7'h10, 32'h1234_5678, 2'd0});
    check("post_clear_issue", {dmi_req_valid_o, dmi_req_addr_o}, {1'b1, 7'h22});
    accept_and_respond(32'hDEAD_BEEF, 2'd2);
    shift_dr('0, 41, dr_out);
    check("err_status", dr_out, {7'h22, 32'hDEAD_BEEF, 2'd2});

    // dmihardreset pulses dmi_rst_no and clears the error.
    shift_ir(5'h10, ir_out);
    shift_dr(41'h0002_0000, 32, dr_out);
    check("dtmcs_sticky2", dr_out, 41'h0000_1871);
    check("hardreset_pulse", dmi_rst_no, 1'b0);
    step(1'b0, 1'b0, d);
    check("hardreset_release", dmi_rst_no, 1'b1);
    shift_dr('0, 32, dr_out);
    check("dtmcs_after_hard", dr_out, 41'h0000_1071);

    // Five TMS=1 cycles return IR to IDCODE.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
    shift_dr('0, 32, dr_out);
    check("tlr_idcode", dr_out, 41'h1000_0001);

    // Reset while a request waits for ready.
    shift_ir(5'h11, ir_out);
    shift_dr({7'h05, 32'h0000_0001, 2'd2}, 41, dr_out);
    check("pre_rst_cap", dr_out, {7'h22, 32'hDEAD_BEEF, 2'd0});
    check("pre_rst_valid", dmi_req_valid_o, 1'b1);
    rst_ni = 1'b0;
    step(1'b0, 1'b0, d);
    rst_ni = 1'b1;
    check("mid_rst_abort", {dmi_req_valid_o, dmi_req_addr_o}, {1'b0, 7'h00});
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
